// File: rtl/shift_register_reader.sv
`default_nettype none
// ============================================================================
// shift_register_reader : window initiator; pushes words, fetches index pairs
// and funnel-shifts them into bit-aligned words. Optional watchdog: SR_TIMEOUT_EN
// Revision: 1.0
// ============================================================================
module shift_register_reader #(
    parameter int WORD_WIDTH  = 32,
    parameter int MAX_SIZE    = 19,
    parameter int POS_WIDTH   = 10,
    parameter int IDX_WIDTH   = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [WORD_WIDTH-1:0] src_word,
    input  logic                  src_valid,
    output logic                  src_ready,
    input  logic [POS_WIDTH-1:0]  req_hi_pos,
    input  logic [POS_WIDTH-1:0]  req_lo_pos,
    input  logic                  req_valid,
    output logic                  req_ready,
    output logic [WORD_WIDTH-1:0] out_hi_word,
    output logic [WORD_WIDTH-1:0] out_lo_word,
    output logic                  out_valid,
    input  logic                  out_ready,
    input  logic                  flush,
    output logic [WORD_WIDTH-1:0] sr_word_in,
    output logic                  sr_word_valid,
    output logic                  sr_clear,
    output logic [IDX_WIDTH-1:0]  sr_high_right_idx,
    output logic [IDX_WIDTH-1:0]  sr_high_left_idx,
    output logic [IDX_WIDTH-1:0]  sr_low_right_idx,
    output logic [IDX_WIDTH-1:0]  sr_low_left_idx,
    output logic                  sr_high_right_valid,
    output logic                  sr_high_left_valid,
    output logic                  sr_low_right_valid,
    output logic                  sr_low_left_valid,
    output logic                  sr_get_pair,
    input  logic [WORD_WIDTH-1:0] sr_high_right_word,
    input  logic [WORD_WIDTH-1:0] sr_high_left_word,
    input  logic [WORD_WIDTH-1:0] sr_low_right_word,
    input  logic [WORD_WIDTH-1:0] sr_low_left_word,
    input  logic                  sr_pair_valid,
    input  logic                  sr_word_accepted,
    input  logic [IDX_WIDTH-1:0]  sr_current_size,
    input  logic                  sr_ready,
    output logic                  err
);
    localparam int LOG2W = $clog2(WORD_WIDTH);
    localparam int CW    = ((POS_WIDTH > IDX_WIDTH) ? POS_WIDTH : IDX_WIDTH) + 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PUSH      = 3'd1;
    localparam logic [2:0] PUSH_WAIT = 3'd2;
    localparam logic [2:0] GET       = 3'd3;
    localparam logic [2:0] GET_WAIT  = 3'd4;
    localparam logic [2:0] OUT       = 3'd5;

    if ((2 ** IDX_WIDTH) <= MAX_SIZE || TIMEOUT_CYC < 1) begin : g_param_check
        $error("shift_register_reader: IDX_WIDTH too small or TIMEOUT_CYC < 1");
    end

    logic [2:0]            state, next_state;
    logic [WORD_WIDTH-1:0] word_q;
    logic [POS_WIDTH-1:0]  hi_pos_q, lo_pos_q;
    logic                  idle_ready;
    logic                  timeout;

    for (genvar i = 0; i < 2; i++) begin : g_pos
        logic [POS_WIDTH-1:0]  pos;
        logic [WORD_WIDTH-1:0] rw, lw, aligned;
        logic [CW-1:0]         wo, size_x, r_diff, l_diff;
        logic [LOG2W-1:0]      b;
        logic [LOG2W:0]        lsh;
        logic                  r_vld, l_vld;
        logic [IDX_WIDTH-1:0]  r_idx, l_idx;

        assign pos = (i == 0) ? hi_pos_q : lo_pos_q;
        assign rw  = (i == 0) ? sr_high_right_word : sr_low_right_word;
        assign lw  = (i == 0) ? sr_high_left_word  : sr_low_left_word;

        // Wide subtraction: an out-of-window offset never wraps into a valid index.
        always_comb begin
            wo      = CW'(pos >> LOG2W);
            b       = pos[LOG2W-1:0];
            size_x  = CW'(sr_current_size);
            r_diff  = size_x - CW'(1) - wo;
            l_diff  = size_x - CW'(2) - wo;
            r_vld   = (wo < size_x);
            l_vld   = ((wo + CW'(1)) < size_x) && (b != '0);
            r_idx   = r_vld ? r_diff[IDX_WIDTH-1:0] : '0;
            l_idx   = l_vld ? l_diff[IDX_WIDTH-1:0] : '0;
            lsh     = (LOG2W + 1)'(WORD_WIDTH) - {1'b0, b};
            aligned = (b == '0) ? rw : ((rw >> b) | (lw << lsh));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        if (flush) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:      if (sr_ready) begin
                               if (src_valid)      next_state = PUSH;
                               else if (req_valid) next_state = GET;
                           end
                PUSH:      next_state = PUSH_WAIT;
                PUSH_WAIT: if (sr_word_accepted || timeout) next_state = IDLE;
                GET:       next_state = GET_WAIT;
                GET_WAIT:  if (sr_pair_valid) next_state = OUT;
                           else if (timeout)  next_state = IDLE;
                OUT:       if (out_ready) next_state = IDLE;
                default:   next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        idle_ready          = (state == IDLE) && sr_ready && !flush;
        src_ready           = idle_ready;
        req_ready           = idle_ready;
        sr_word_valid       = (state == PUSH) && !flush;
        sr_get_pair         = (state == GET) && !flush;
        out_valid           = (state == OUT) && !flush;
        sr_high_right_valid = sr_get_pair && g_pos[0].r_vld;
        sr_high_left_valid  = sr_get_pair && g_pos[0].l_vld;
        sr_low_right_valid  = sr_get_pair && g_pos[1].r_vld;
        sr_low_left_valid   = sr_get_pair && g_pos[1].l_vld;
        sr_high_right_idx   = sr_get_pair ? g_pos[0].r_idx : '0;
        sr_high_left_idx    = sr_get_pair ? g_pos[0].l_idx : '0;
        sr_low_right_idx    = sr_get_pair ? g_pos[1].r_idx : '0;
        sr_low_left_idx     = sr_get_pair ? g_pos[1].l_idx : '0;
    end

    assign sr_word_in = word_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q      <= '0;
            hi_pos_q    <= '0;
            lo_pos_q    <= '0;
            out_hi_word <= '0;
            out_lo_word <= '0;
            sr_clear    <= 1'b0;
        end else begin
            sr_clear <= flush | timeout;
            if (idle_ready) begin
                if (src_valid) begin
                    word_q <= src_word;
                end else if (req_valid) begin
                    hi_pos_q <= req_hi_pos;
                    lo_pos_q <= req_lo_pos;
                end
            end
            if (state == GET_WAIT && sr_pair_valid && !flush) begin
                out_hi_word <= g_pos[0].aligned;
                out_lo_word <= g_pos[1].aligned;
            end
        end
    end

`ifdef SR_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] wait_cnt;
    logic          waiting;
    logic          err_q;

    assign waiting = ((state == PUSH_WAIT) && !sr_word_accepted) ||
                     ((state == GET_WAIT)  && !sr_pair_valid);
    assign timeout = waiting && !flush && (wait_cnt == TW'(TIMEOUT_CYC - 1));
    assign err     = err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (flush)        err_q <= 1'b0;
            else if (timeout) err_q <= 1'b1;
            if (waiting && !flush && !timeout) wait_cnt <= wait_cnt + TW'(1);
            else                               wait_cnt <= '0;
        end
    end
`else
    assign timeout = 1'b0;
    assign err     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_shift_register_reader.sv
`default_nettype none
// Bench for shift_register_reader: behavioural window responder plus a
// scoreboard whose expectations come from a flat bit-vector of pushed words.
module tb_shift_register_reader;
    localparam int W        = 32;
    localparam int MAXS     = 19;
    localparam int PW       = 10;
    localparam int IW       = 5;
    localparam int TO       = 15;
    localparam int RESP_LAT = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  src_word;
    logic          src_valid, src_ready;
    logic [PW-1:0] req_hi_pos, req_lo_pos;
    logic          req_valid, req_ready;
    logic [W-1:0]  out_hi_word, out_lo_word;
    logic          out_valid, out_ready, flush;
    logic [W-1:0]  sr_word_in;
    logic          sr_word_valid, sr_clear, sr_get_pair;
    logic [IW-1:0] sr_high_right_idx, sr_high_left_idx, sr_low_right_idx, sr_low_left_idx;
    logic          sr_high_right_valid, sr_high_left_valid, sr_low_right_valid, sr_low_left_valid;
    logic [W-1:0]  sr_high_right_word, sr_high_left_word, sr_low_right_word, sr_low_left_word;
    logic          sr_pair_valid, sr_word_accepted, sr_ready;
    logic [IW-1:0] sr_current_size;
    logic          err;

    shift_register_reader #(
        .WORD_WIDTH(W), .MAX_SIZE(MAXS), .POS_WIDTH(PW), .IDX_WIDTH(IW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .src_word(src_word), .src_valid(src_valid), .src_ready(src_ready),
        .req_hi_pos(req_hi_pos), .req_lo_pos(req_lo_pos), .req_valid(req_valid), .req_ready(req_ready),
        .out_hi_word(out_hi_word), .out_lo_word(out_lo_word), .out_valid(out_valid), .out_ready(out_ready),
        .flush(flush),
        .sr_word_in(sr_word_in), .sr_word_valid(sr_word_valid), .sr_clear(sr_clear),
        .sr_high_right_idx(sr_high_right_idx), .sr_high_left_idx(sr_high_left_idx),
        .sr_low_right_idx(sr_low_right_idx), .sr_low_left_idx(sr_low_left_idx),
        .sr_high_right_valid(sr_high_right_valid), .sr_high_left_valid(sr_high_left_valid),
        .sr_low_right_valid(sr_low_right_valid), .sr_low_left_valid(sr_low_left_valid),
        .sr_get_pair(sr_get_pair),
        .sr_high_right_word(sr_high_right_word), .sr_high_left_word(sr_high_left_word),
        .sr_low_right_word(sr_low_right_word), .sr_low_left_word(sr_low_left_word),
        .sr_pair_valid(sr_pair_valid), .sr_word_accepted(sr_word_accepted),
        .sr_current_size(sr_current_size), .sr_ready(sr_ready), .err(err)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference window: newest word occupies bits [W-1:0] of a flat vector.
    logic [W-1:0]   ref_win [$];
    logic [2*W-1:0] exp_q [$];
    logic [2*W-1:0] last_out;

    function automatic logic [2*W-1:0] ref_pair(input logic [PW-1:0] hp, input logic [PW-1:0] lp);
        logic [(1<<PW)+W-1:0] flat;
        flat = '0;
        for (int k = 0; k < ref_win.size(); k++)
            flat[k*W +: W] = ref_win[ref_win.size()-1-k];
        return {flat[hp +: W], flat[lp +: W]};
    endfunction

    int wv_cnt = 0;
    int clr_cnt = 0;

    initial begin
        last_out = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (sr_word_valid) wv_cnt++;
                if (sr_clear)      clr_cnt++;
                if (flush) begin
                    ref_win.delete();
                    exp_q.delete();
                    check("flush_blocks_ready", {src_ready, req_ready}, 2'b00);
                end else begin
                    if (out_valid) begin
                        if (exp_q.size() == 0) begin
                            check("spurious_out", out_valid, 1'b0);
                        end else begin
                            check("out_hi_lo", {out_hi_word, out_lo_word}, exp_q[0]);
                            if (out_ready) begin
                                last_out = {out_hi_word, out_lo_word};
                                void'(exp_q.pop_front());
                            end
                        end
                    end
                    if (src_valid && src_ready) begin
                        ref_win.push_back(src_word);
                        if (ref_win.size() > MAXS) void'(ref_win.pop_front());
                    end else if (req_valid && req_ready) begin
                        exp_q.push_back(ref_pair(req_hi_pos, req_lo_pos));
                    end
                end
            end
        end
    end

    // Behavioural window: samples requests at negedge, responds after posedge.
    logic         hold_resp;
    logic [W-1:0] win_mem [MAXS];
    int           win_size;
    int           resp_cnt;

    initial begin
        logic          s_rst, s_wv, s_gp, s_clr;
        logic [W-1:0]  s_w;
        logic [3:0]    s_v, c_v;
        logic [IW-1:0] s_i [4];
        logic [IW-1:0] c_i [4];
        sr_word_accepted = 0; sr_pair_valid = 0;
        sr_high_right_word = '0; sr_high_left_word = '0;
        sr_low_right_word = '0; sr_low_left_word = '0;
        win_size = 0; resp_cnt = 0; sr_current_size = '0;
        c_v = '0;
        for (int k = 0; k < 4; k++) c_i[k] = '0;
        forever begin
            @(negedge clk);
            s_rst = rst_n; s_wv = sr_word_valid; s_gp = sr_get_pair; s_clr = sr_clear; s_w = sr_word_in;
            s_v = {sr_high_right_valid, sr_high_left_valid, sr_low_right_valid, sr_low_left_valid};
            s_i[0] = sr_high_right_idx; s_i[1] = sr_high_left_idx;
            s_i[2] = sr_low_right_idx;  s_i[3] = sr_low_left_idx;
            @(posedge clk); #1;
            sr_word_accepted = 0; sr_pair_valid = 0;
            sr_high_right_word = '0; sr_high_left_word = '0;
            sr_low_right_word = '0; sr_low_left_word = '0;
            if (!s_rst || s_clr) begin
                win_size = 0;
                resp_cnt = 0;
            end else begin
                if (s_wv) begin
                    if (win_size == MAXS) begin
                        for (int k = 0; k < MAXS-1; k++) win_mem[k] = win_mem[k+1];
                        win_mem[MAXS-1] = s_w;
                    end else begin
                        win_mem[win_size] = s_w;
                        win_size++;
                    end
                    sr_word_accepted = 1;
                end
                if (s_gp) begin
                    c_v = s_v;
                    c_i = s_i;
                    resp_cnt = RESP_LAT;
                end else if (resp_cnt > 0) begin
                    resp_cnt--;
                    if (resp_cnt == 0 && !hold_resp) begin
                        sr_pair_valid = 1;
                        sr_high_right_word = c_v[3] ? win_mem[c_i[0]] : '0;
                        sr_high_left_word  = c_v[2] ? win_mem[c_i[1]] : '0;
                        sr_low_right_word  = c_v[1] ? win_mem[c_i[2]] : '0;
                        sr_low_left_word   = c_v[0] ? win_mem[c_i[3]] : '0;
                    end
                end
            end
            sr_current_size = IW'(win_size);
        end
    end

    task automatic do_push(input logic [W-1:0] w);
        bit ok;
        ok = 0;
        @(posedge clk); #1;
        src_valid = 1; src_word = w;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = src_ready;
        end
        @(posedge clk); #1;
        src_valid = 0;
        if (!ok) check("push_accept_timeout", src_ready, 1'b1);
    endtask

    task automatic wait_req_accept();
        bit ok;
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready && !src_valid;
        end
        @(posedge clk); #1;
        req_valid = 0;
        if (!ok) check("req_accept_timeout", req_ready, 1'b1);
    endtask

    task automatic do_req(input logic [PW-1:0] hp, input logic [PW-1:0] lp);
        @(posedge clk); #1;
        req_valid = 1; req_hi_pos = hp; req_lo_pos = lp;
        wait_req_accept();
    endtask

    task automatic check_idx(input string tag, input logic [23:0] exp);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = sr_get_pair;
        end
        check(tag, {sr_get_pair, sr_high_right_valid, sr_high_left_valid, sr_low_right_valid, sr_low_left_valid,
                    sr_high_right_idx, sr_high_left_idx, sr_low_right_idx, sr_low_left_idx}, {1'b1, exp});
    endtask

    task automatic wait_drain();
        int i;
        i = 0;
        while ((exp_q.size() != 0 || out_valid) && i < 200) begin
            @(negedge clk);
            i++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    task automatic flush_pulse();
        @(posedge clk); #1; flush = 1;
        @(posedge clk); #1; flush = 0;
        @(negedge clk);
        check("sr_clear_pulse", sr_clear, 1'b1);
        @(negedge clk);
        check("sr_clear_single", sr_clear, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        logic [W-1:0]   newest;
        logic [2*W-1:0] held;
        int             wv0, clr0;
        bit             got;
        src_valid = 0; src_word = '0; req_valid = 0; req_hi_pos = '0; req_lo_pos = '0;
        out_ready = 1; flush = 0; sr_ready = 1; hold_resp = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {out_valid, sr_word_valid, sr_get_pair, sr_clear, err, src_ready, req_ready}, 7'b0000011);
        check("reset_data", {out_hi_word, out_lo_word}, 64'h0);
        check("reset_word_in", sr_word_in, 32'h0);
        @(posedge clk); #1; rst_n = 1;

        wv0 = wv_cnt;
        do_push(32'h11111111);
        do_push(32'h22222222);
        do_push(32'h33333333);
        repeat (4) @(negedge clk);
        check("push_pulses", wv_cnt - wv0, 3);
        check("window_size", win_size, 3);

        do_req(10'd0, 10'd32);
        check_idx("idx_aligned", {4'b1010, 5'd2, 5'd0, 5'd1, 5'd0});
        wait_drain();
        check("tp_aligned", last_out, 64'h33333333_22222222);

        flush_pulse();
        do_push(32'h0000000F);
        do_push(32'h000000F0);
        do_req(10'd4, 10'd36);
        check_idx("idx_funnel", {4'b1110, 5'd1, 5'd0, 5'd0, 5'd0});
        wait_drain();
        check("tp_funnel", last_out, 64'hF000000F_00000000);

        // Overfill the window so the oldest words fall out, then probe it.
        flush_pulse();
        for (int i = 0; i < MAXS + 3; i++) do_push($urandom);
        for (int i = 0; i < 8; i++) begin
            do_req(PW'($urandom_range(0, 700)), PW'($urandom_range(0, 1023)));
            wait_drain();
        end
        do_req(10'd577, 10'd608);
        wait_drain();
        newest = ref_win[ref_win.size()-1];

        // Simultaneous push and request, output held with out_ready low.
        out_ready = 0;
        @(posedge clk); #1;
        src_valid = 1; src_word = 32'hA5A55A5A;
        req_valid = 1; req_hi_pos = 10'd0; req_lo_pos = 10'd32;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clk);
            got = src_ready;
        end
        @(posedge clk); #1; src_valid = 0;
        wait_req_accept();
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            got = out_valid;
        end
        check("hold_valid_seen", out_valid, 1'b1);
        held = {out_hi_word, out_lo_word};
        repeat (3) @(negedge clk);
        check("hold_valid", out_valid, 1'b1);
        check("hold_stable", {out_hi_word, out_lo_word}, held);
        @(posedge clk); #1; out_ready = 1;
        wait_drain();
        check("push_before_req", last_out, {32'hA5A55A5A, newest});

        // Flush while waiting on the window.
        hold_resp = 1;
        do_req(10'd0, 10'd0);
        check_idx("idx_pre_flush", {4'b1010, 5'd18, 5'd0, 5'd18, 5'd0});
        flush_pulse();
        hold_resp = 0;
        repeat (8) @(negedge clk);
        check("no_out_after_flush", out_valid, 1'b0);
        do_req(10'd5, 10'd40);
        check_idx("idx_empty", {4'b0000, 5'd0, 5'd0, 5'd0, 5'd0});
        wait_drain();
        check("empty_window", last_out, 64'h0);

`ifdef SR_TIMEOUT_EN
        do_push(32'hCAFEF00D);
        hold_resp = 1;
        clr0 = clr_cnt;
        do_req(10'd0, 10'd0);
        repeat (TO - 1) @(negedge clk);
        check("err_before_limit", err, 1'b0);
        repeat (5) @(negedge clk);
        check("err_timeout", err, 1'b1);
        check("timeout_clear", clr_cnt - clr0, 1);
        check("timeout_no_out", out_valid, 1'b0);
        exp_q.delete();
        ref_win.delete();
        hold_resp = 0;
        flush_pulse();
        check("err_flushed", err, 1'b0);
`else
        clr0 = clr_cnt;
        check("err_tied_low", err, 1'b0);
`endif

        @(posedge clk); #1; sr_ready = 0;
        @(negedge clk);
        check("sr_not_ready", {src_ready, req_ready}, 2'b00);
        @(posedge clk); #1; sr_ready = 1;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
